// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default parameters
// for the instruction-fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DROP = 2'd3
   } fetch_state_e;

   localparam int unsigned FETCH_ADDR_WIDTH  = 5;
   localparam int unsigned FETCH_INSTR_WIDTH = 32;
   localparam int unsigned FETCH_RESET_ADDR  = 0;

   localparam int unsigned FETCH_CNT_WIDTH  = 16;
   localparam int unsigned FETCH_DROP_WIDTH = 8;

endpackage

// File: rtl/fetch_out_buf.sv
// fetch_out_buf: one-entry valid/ready register holding a fetched
// word and its address; flush empties it without touching the data.
module fetch_out_buf
   import fetch_pkg::*;
#(
   parameter int unsigned INSTR_WIDTH = FETCH_INSTR_WIDTH,
   parameter int unsigned ADDR_WIDTH  = FETCH_ADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [INSTR_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0]  wr_pc,
   input  logic                   rd_ready,
   output logic                   valid,
   output logic [INSTR_WIDTH-1:0] data,
   output logic [ADDR_WIDTH-1:0]  pc
);

   logic                   valid_q, valid_d;
   logic [INSTR_WIDTH-1:0] data_q, data_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;

   // A write in the same cycle as an accept refills with no bubble.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      pc_d    = pc_q;
      priority case (1'b1)
         flush: begin
            valid_d = 1'b0;
         end
         wr_en: begin
            valid_d = 1'b1;
            data_d  = wr_data;
            pc_d    = wr_pc;
         end
         rd_ready: begin
            valid_d = 1'b0;
         end
         default: begin
            valid_d = valid_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         pc_q    <= pc_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
   assign pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer driving an
// external PC counter. FETCH_PERF_CNT_EN adds fetch/drop counters.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = FETCH_ADDR_WIDTH,
   parameter int unsigned INSTR_WIDTH = FETCH_INSTR_WIDTH,
   parameter int unsigned RESET_ADDR  = FETCH_RESET_ADDR
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_WIDTH-1:0]  pc_in,
   output logic                   pc_load,
   output logic                   pc_enable,
   output logic [ADDR_WIDTH-1:0]  pc_target,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_addr,
   input  logic                   halt,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic                   imem_rvalid,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_WIDTH-1:0] instr_data,
   output logic [ADDR_WIDTH-1:0]  instr_pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [15:0]            fetch_count,
   output logic [7:0]             drop_count,
`endif
   output logic                   busy
);

   localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_ADDR);

   fetch_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;

   logic                  load_c;
   logic                  en_c;
   logic [ADDR_WIDTH-1:0] target_c;
   logic                  req_c;
   logic [ADDR_WIDTH-1:0] addr_c;
   logic                  wr_c;
   logic                  flush_c;
   logic                  drop_c;
   logic                  slot_blocked;

   // Only request when the slot is empty or being drained this cycle,
   // so the single response always has somewhere to land.
   assign slot_blocked = instr_valid && !instr_ready;

   always_comb begin
      state_d  = state_q;
      req_pc_d = req_pc_q;
      load_c   = 1'b0;
      en_c     = 1'b0;
      target_c = '0;
      req_c    = 1'b0;
      addr_c   = '0;
      wr_c     = 1'b0;
      flush_c  = 1'b0;
      drop_c   = 1'b0;
      unique case (state_q)
         S_INIT: begin
            load_c   = 1'b1;
            target_c = redirect_valid ? redirect_addr : RST_PC;
            state_d  = S_REQ;
         end
         S_REQ: begin
            if (redirect_valid) begin
               load_c   = 1'b1;
               target_c = redirect_addr;
               flush_c  = 1'b1;
            end else if (!halt && !slot_blocked) begin
               req_c    = 1'b1;
               addr_c   = pc_in;
               req_pc_d = pc_in;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               load_c   = 1'b1;
               target_c = redirect_addr;
               flush_c  = 1'b1;
               state_d  = imem_rvalid ? S_REQ : S_DROP;
            end else if (imem_rvalid) begin
               wr_c    = 1'b1;
               en_c    = 1'b1;
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (redirect_valid) begin
               load_c   = 1'b1;
               target_c = redirect_addr;
               flush_c  = 1'b1;
            end
            if (imem_rvalid) begin
               drop_c  = 1'b1;
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_INIT;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
      end
   end

   // Held low in reset so the counter never sees a load from S_INIT early.
   assign pc_load   = rst_n && load_c;
   assign pc_enable = rst_n && en_c;
   assign pc_target = rst_n ? target_c : '0;
   assign imem_req  = rst_n && req_c;
   assign imem_addr = rst_n ? addr_c : '0;

   fetch_out_buf #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH)
   ) u_out_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush_c),
      .wr_en    (wr_c),
      .wr_data  (imem_rdata),
      .wr_pc    (req_pc_q),
      .rd_ready (instr_ready),
      .valid    (instr_valid),
      .data     (instr_data),
      .pc       (instr_pc)
   );

   assign busy = (state_q != S_REQ) || instr_valid;

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_count_q, fetch_count_d;
   logic [7:0]  drop_count_q, drop_count_d;

   always_comb begin
      fetch_count_d = fetch_count_q;
      drop_count_d  = drop_count_q;
      if (instr_valid && instr_ready && (fetch_count_q != 16'hFFFF)) begin
         fetch_count_d = fetch_count_q + 16'd1;
      end
      if (drop_c && (drop_count_q != 8'hFF)) begin
         drop_count_d = drop_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count_q <= '0;
         drop_count_q  <= '0;
      end else begin
         fetch_count_q <= fetch_count_d;
         drop_count_q  <= drop_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
   assign drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table plus randomized stream checking
// for fetch_ctrl with a behavioural PC counter and memory beside it.
module tb_fetch_ctrl;

   localparam int AW = 5;
   localparam int IW = 32;
   localparam int RA = 4;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] pc_in;
   logic          pc_load;
   logic          pc_enable;
   logic [AW-1:0] pc_target;
   logic          redirect_valid;
   logic [AW-1:0] redirect_addr;
   logic          halt;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_rvalid;
   logic [IW-1:0] imem_rdata;
   logic          instr_valid;
   logic          instr_ready;
   logic [IW-1:0] instr_data;
   logic [AW-1:0] instr_pc;
   logic          busy;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0]   fetch_count;
   logic [7:0]    drop_count;
`endif

   fetch_ctrl #(
      .ADDR_WIDTH  (AW),
      .INSTR_WIDTH (IW),
      .RESET_ADDR  (RA)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc_in          (pc_in),
      .pc_load        (pc_load),
      .pc_enable      (pc_enable),
      .pc_target      (pc_target),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halt           (halt),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
`ifdef FETCH_PERF_CNT_EN
      .fetch_count    (fetch_count),
      .drop_count     (drop_count),
`endif
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External program counter: load wins, otherwise enable increments.
   logic [AW-1:0] pc_model;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_model <= '0;
      else if (pc_load) pc_model <= pc_target;
      else if (pc_enable) pc_model <= pc_model + 1'b1;
   end
   assign pc_in = pc_model;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp,
                  $time);
      end
   endtask

   // Memory: answers 0x100+addr, lat cycles after the request.
   logic          mem_pend = 1'b0;
   int            mem_cnt  = 0;
   logic [AW-1:0] mem_addr = '0;

   task automatic drive_cycle(input logic rv, input logic [AW-1:0] ra,
                              input logic h, input logic rdy,
                              input int lat);
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (mem_pend) begin
         if (mem_cnt <= 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h100 + 32'(mem_addr);
            mem_pend    = 1'b0;
         end else begin
            mem_cnt--;
         end
      end
      redirect_valid = rv;
      redirect_addr  = ra;
      halt           = h;
      instr_ready    = rdy;
      #1;
      if (imem_req) begin
         chk("single_outstanding", 32'(mem_pend), 32'd0);
         mem_pend = 1'b1;
         mem_cnt  = lat;
         mem_addr = imem_addr;
      end
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic quiesce();
      mem_pend       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      halt           = 1'b0;
      instr_ready    = 1'b1;
   endtask

   typedef struct {
      logic          rv;
      logic [AW-1:0] ra;
      logic          h;
      logic          rdy;
      int            lat;
      logic          e_req;
      logic [AW-1:0] e_addr;
      logic          e_load;
      logic [AW-1:0] e_tgt;
      logic          e_en;
      logic          e_val;
      logic [AW-1:0] e_pc;
   } vec_t;

   function automatic vec_t mk(logic rv, logic [AW-1:0] ra, logic h,
                               logic rdy, int lat, logic e_req,
                               logic [AW-1:0] e_addr, logic e_load,
                               logic [AW-1:0] e_tgt, logic e_en,
                               logic e_val, logic [AW-1:0] e_pc);
      vec_t v;
      v.rv = rv; v.ra = ra; v.h = h; v.rdy = rdy; v.lat = lat;
      v.e_req = e_req; v.e_addr = e_addr; v.e_load = e_load;
      v.e_tgt = e_tgt; v.e_en = e_en; v.e_val = e_val; v.e_pc = e_pc;
      return v;
   endfunction

   vec_t tv[$];

   initial begin
      logic [AW-1:0] exp_pc;
      logic          prev_hold;
      logic [AW-1:0] prev_pc;
      logic [IW-1:0] prev_data;
      int            accepts;
      logic          rv;
      logic [AW-1:0] ra;
      logic          h;
      logic          rdy;

      // rv ra h rdy lat | req addr load tgt en val pc
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 4, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 4, 0, 0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 5, 0, 0, 0, 1, 4));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 6, 0, 0, 0, 1, 5));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 7, 0, 0, 0, 1, 6));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 8, 0, 0, 0, 1, 7));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
      for (int k = 0; k < 5; k++)
         tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 8));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 9, 0, 0, 0, 1, 8));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 3, 1, 10, 0, 0, 0, 1, 9));
      tv.push_back(mk(1, 16, 0, 1, 1, 0, 0, 1, 16, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 16, 0, 0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 17, 0, 0, 0, 1, 16));
      tv.push_back(mk(1, 30, 0, 1, 1, 0, 0, 1, 30, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 30, 0, 0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 31, 0, 0, 0, 1, 30));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 31));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 2, 0, 0, 0, 1, 1));
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
      tv.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 2));
      tv.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0));

      rst_n = 1'b0;
      quiesce();
      #1;
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_load", 32'(pc_load), 32'd0);
      repeat (3) @(posedge clk);
      release_reset();

      for (int i = 0; i < tv.size(); i++) begin
         drive_cycle(tv[i].rv, tv[i].ra, tv[i].h, tv[i].rdy, tv[i].lat);
         chk($sformatf("tv%0d_req", i), 32'(imem_req), 32'(tv[i].e_req));
         if (tv[i].e_req)
            chk($sformatf("tv%0d_addr", i), 32'(imem_addr),
                32'(tv[i].e_addr));
         chk($sformatf("tv%0d_load", i), 32'(pc_load), 32'(tv[i].e_load));
         if (tv[i].e_load)
            chk($sformatf("tv%0d_tgt", i), 32'(pc_target),
                32'(tv[i].e_tgt));
         chk($sformatf("tv%0d_en", i), 32'(pc_enable), 32'(tv[i].e_en));
         chk($sformatf("tv%0d_val", i), 32'(instr_valid),
             32'(tv[i].e_val));
         if (tv[i].e_val) begin
            chk($sformatf("tv%0d_pc", i), 32'(instr_pc), 32'(tv[i].e_pc));
            chk($sformatf("tv%0d_data", i), instr_data,
                32'h100 + 32'(tv[i].e_pc));
         end
      end
      chk("busy_idle", 32'(busy), 32'd0);

      // Async reset in S_WAIT with a stale word still in the slot regs.
      drive_cycle(0, 0, 0, 1, 1);
      chk("busy_wait", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(instr_valid), 32'd0);
      chk("arst_data", instr_data, 32'd0);
      chk("arst_pc", 32'(instr_pc), 32'd0);
      chk("arst_req", 32'(imem_req), 32'd0);
      chk("arst_load", 32'(pc_load), 32'd0);
      chk("arst_en", 32'(pc_enable), 32'd0);
      chk("arst_tgt", 32'(pc_target), 32'd0);
      quiesce();
      release_reset();
      drive_cycle(0, 0, 0, 1, 1);
      chk("rel_load", 32'(pc_load), 32'd1);
      chk("rel_tgt", 32'(pc_target), 32'(RA));
      drive_cycle(0, 0, 0, 1, 1);
      chk("rel_req", 32'(imem_req), 32'd1);
      chk("rel_addr", 32'(imem_addr), 32'(RA));
      drive_cycle(0, 0, 0, 0, 1);
      drive_cycle(0, 0, 0, 0, 1);
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_pc", 32'(instr_pc), 32'(RA));
      rst_n = 1'b0;
      #1;
      chk("arst2_valid", 32'(instr_valid), 32'd0);
      chk("arst2_data", instr_data, 32'd0);
      quiesce();
      release_reset();

      // Randomized run against an in-order fetch-stream model.
      exp_pc    = AW'(RA);
      prev_hold = 1'b0;
      prev_pc   = '0;
      prev_data = '0;
      accepts   = 0;
      for (int c = 0; c < 3000; c++) begin
         rv  = ($urandom_range(15) == 0);
         ra  = AW'($urandom_range(31));
         h   = ($urandom_range(7) == 0);
         rdy = ($urandom_range(3) != 0);
         drive_cycle(rv, ra, h, rdy, int'($urandom_range(1, 4)));
         chk("load_en_excl", 32'(pc_load && pc_enable), 32'd0);
         if (rv) begin
            chk("redir_load", 32'(pc_load), 32'd1);
            chk("redir_tgt", 32'(pc_target), 32'(ra));
         end
         if (imem_req) begin
            chk("req_gate", 32'(h || rv || (instr_valid && !rdy)), 32'd0);
            chk("req_addr", 32'(imem_addr), 32'(pc_model));
         end
         if (prev_hold) begin
            chk("hold_stable_v", 32'(instr_valid), 32'd1);
            chk("hold_stable_pc", 32'(instr_pc), 32'(prev_pc));
            chk("hold_stable_d", instr_data, prev_data);
         end
         if (instr_valid && rdy) begin
            chk("stream_pc", 32'(instr_pc), 32'(exp_pc));
            chk("stream_data", instr_data, 32'h100 + 32'(exp_pc));
            exp_pc = exp_pc + 1'b1;
            accepts++;
         end
         if (rv) exp_pc = ra;
         prev_hold = instr_valid && !rdy && !rv;
         prev_pc   = instr_pc;
         prev_data = instr_data;
      end
      chk("progress", 32'(accepts > 100), 32'd1);
`ifdef FETCH_PERF_CNT_EN
      @(negedge clk);
      chk("fetch_count", 32'(fetch_count),
          32'(accepts > 65535 ? 65535 : accepts));
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that sits directly upstream of the program-address counter (a counter_gen instance, WIDTH = ADDR_WIDTH).
- Drives the counter's load, enable and count_in, and reads back its count_out as the current PC.
- Issues single-outstanding requests to instruction memory and presents fetched words to decode through a one-entry valid/ready output register.
- Handles redirects (branch/jump) and halt.

Parameters:
- ADDR_WIDTH, 5: PC width; must equal the counter WIDTH.
- INSTR_WIDTH, 32: instruction word width.
- RESET_ADDR, 0: first fetch address after reset.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_in  in  ADDR_WIDTH  counter count_out (current PC).
- pc_load  out  1  to counter load.
- pc_enable  out  1  to counter enable.
- pc_target  out  ADDR_WIDTH  to counter count_in.
- redirect_valid  in  1  one-cycle redirect request.
- redirect_addr  in  ADDR_WIDTH  redirect target.
- halt  in  1  level; blocks new requests while high.
- imem_req  out  1  one-cycle request strobe.
- imem_addr  out  ADDR_WIDTH  request address.
- imem_rvalid  in  1  response strobe; 1..N cycles after imem_req.
- imem_rdata  in  INSTR_WIDTH  response data.
- instr_valid  out  1  output slot holds an instruction.
- instr_ready  in  1  decode accepts.
- instr_data  out  INSTR_WIDTH  fetched word.
- instr_pc  out  ADDR_WIDTH  address of instr_data.
- busy  out  1  high when state is not S_REQ, or instr_valid is high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = S_INIT.
  - All outputs 0: instr_valid, instr_data, instr_pc, imem_req, pc_load, pc_enable, pc_target.
  - Internal req_pc = 0.
- Combinational outputs: pc_load, pc_enable, pc_target, imem_req and imem_addr are combinational from state and inputs. pc_load and pc_enable are never both high.
- S_INIT: pc_load=1, pc_target = redirect_valid ? redirect_addr : RESET_ADDR. Go to S_REQ.
- S_REQ, in priority order:
  - redirect_valid: pc_load=1, pc_target=redirect_addr, clear instr_valid, no request, stay.
  - halt, or (instr_valid and !instr_ready): no request, stay.
  - Otherwise: imem_req=1, imem_addr=pc_in, req_pc<=pc_in, go to S_WAIT.
- S_WAIT:
  - redirect_valid (with or without imem_rvalid the same cycle): pc_load=1, clear instr_valid. Go to S_REQ if imem_rvalid this cycle, else S_DROP.
  - imem_rvalid: instr_data<=imem_rdata, instr_pc<=req_pc, instr_valid<=1, pc_enable=1, go to S_REQ.
  - Otherwise stay.
- S_DROP: wait for imem_rvalid and discard the data, then go to S_REQ.
  - A second redirect in S_DROP: pc_load=1 with the new target; stay in S_DROP.
- Output handshake: instr_valid clears on (instr_ready and no new write). A simultaneous accept and write replaces the slot with no bubble.
- Slot-free rule: a request is issued only when the slot is empty or draining that cycle, so a response is never lost.
- PC arithmetic: increment by 1 happens in the counter. Wrap 2^ADDR_WIDTH-1 -> 0 is normal; fetch continues at 0.
- Counter latency: pc_in updates the cycle after pc_load or pc_enable. Every path into S_REQ spends at least one cycle elsewhere, so pc_in is always current when sampled.
- Minimum latency: reset release -> S_INIT (cycle 0) -> imem_req at RESET_ADDR (cycle 1) -> instr_valid in the cycle after rvalid. Steady-state throughput is one instruction per 2 cycles with 1-cycle memory.
- halt: never aborts an outstanding request; that response completes normally.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count (16 bits, reset 0).
  - Increments on each instr_valid & instr_ready; saturates at 0xFFFF.
  - Adds output drop_count (8 bits, saturating), incremented on each response discarded in S_DROP.
- Undefined: neither port nor either register exists; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg contains:
  - State enum: S_INIT, S_REQ, S_WAIT, S_DROP.
  - Default localparams for ADDR_WIDTH, INSTR_WIDTH and RESET_ADDR.
- One natural sub-module, fetch_out_buf: a one-entry valid/ready register with flush input, parameterised by INSTR_WIDTH and ADDR_WIDTH.
- The counter itself stays external, instantiated beside fetch_ctrl.

Test Plan:
- Reset release, RESET_ADDR=4, 1-cycle memory returning 0x100+addr, instr_ready=1 -> instr_pc sequence 4,5,6,7 with instr_data 0x104.. and one instruction per 2 cycles.
- instr_ready=0 for 5 cycles after the first instruction -> instr_valid held, instr_data stable, no imem_req while the slot is full; fetch resumes the cycle ready rises.
- redirect_valid to 0x10 in S_WAIT with memory latency 3 -> response discarded; next imem_addr=0x10; no instruction from the old PC ever appears on the output.
- redirect_valid in the same cycle as imem_rvalid -> data dropped, pc_load=1, pc_enable=0; next fetch at the target.
- Start at 0x1E with ADDR_WIDTH=5 -> fetch 0x1E, 0x1F, 0x00, 0x01.
- rst_n pulled low while in S_WAIT with instr_valid=1 -> all outputs 0 immediately; after release, S_INIT reloads RESET_ADDR.
- With FETCH_PERF_CNT_EN: 10 accepted instructions gives fetch_count=10; one dropped response gives drop_count=1.
